// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared constants and pointer helper for the FIFO read streamer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int BUF_DEPTH  = 3;
  localparam int PTR_W      = 2;
  localparam int OCC_W      = 2;
  localparam int XFER_CNT_W = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  // Circular increment over a 3-entry ring: 0 -> 1 -> 2 -> 0
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : rd_skid_buf
// Brief    : 3-entry circular output buffer with push, pop, clear and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int BUF_DEPTH = fifo_rd_pkg::BUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_head_data,
  output logic [OCC_W-1:0]  o_occ
);

  logic [DWIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t              r_head;
  ptr_t              r_tail;
  logic [OCC_W-1:0]  r_occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (i_clear) begin
      // Clear outranks push so a word landing with the clear is dropped
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (i_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head_data = r_mem[r_head];
  assign o_occ       = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Drains a registered-output sync FIFO into a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int BUF_DEPTH = fifo_rd_pkg::BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DWIDTH-1:0]     fifo_dout,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DWIDTH-1:0]     m_data,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  busy
);

  logic                  r_inflight;
  logic [XFER_CNT_W-1:0] r_xfer_cnt;
  logic [OCC_W-1:0]      w_occ;
  logic [DWIDTH-1:0]     w_head_data;
  logic                  w_pop;
  logic                  w_credit_ok;

  // Credit uses only registered state, keeping m_ready out of the read path
  assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(BUF_DEPTH);
  assign fifo_rd_en  = !reset && !flush && !fifo_empty && w_credit_ok;
  assign w_pop       = m_valid && m_ready;

  rd_skid_buf #(
    .DWIDTH    (DWIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (flush),
    .i_push      (r_inflight),
    .i_push_data (fifo_dout),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_occ       (w_occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (w_pop) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
    end
  end

  assign m_valid  = (w_occ != '0);
  assign m_data   = w_head_data;
  assign xfer_cnt = r_xfer_cnt;
  assign busy     = (w_occ != '0) || r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Scoreboard bench driving fifo_rd_stream from a sync FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_dout = '0;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [15:0] xfer_cnt;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt = '0;

  // Sync FIFO model: registered dout, read accepted only when not empty
  logic [15:0] mem [0:131071];
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_cnt[16:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  fifo_rd_stream #(.DWIDTH(16), .BUF_DEPTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .xfer_cnt   (xfer_cnt),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    mem[wr_cnt[16:0]] = d;
    wr_cnt = wr_cnt + 1;
    exp_q.push_back(d);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid || busy || !fifo_empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", 32'(k < budget), 32'd1);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // Monitor: every handshake pops the scoreboard
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h expected none (t=%0t)", m_data, $time);
      end else begin
        chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Buffer credit invariant
  always @(negedge clk) begin
    if (!reset) begin
      chk("no_overflow", 32'(({1'b0, dut.w_occ} + {2'b00, dut.r_inflight}) <= 3'd3), 32'd1);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Reset state
    repeat (4) tick();
    @(negedge clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    tick();
    reset = 1'b0;

    // Five words back-to-back, first valid two cycles after first read
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) load(16'(i));
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_first_rd_en", 32'(fifo_rd_en), 32'd1);
      if (k <= 6) chk("t1_valid_timing", 32'(m_valid), 32'((k >= 2) ? 1 : 0));
      if (k == 7) chk("t1_xfer_cnt", 32'(xfer_cnt), 32'd5);
      tick();
    end
    drain(50);

    // Six words with downstream stalled: only three reads, head held
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(16'h0B00 + 16'(i));
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
      if (k >= 4) chk("t2_head_stable", 32'(m_data), 32'h0B00);
      tick();
    end
    chk("t2_rd_pulses", 32'(pulses), 32'd3);
    chk("t2_fifo_left", 32'(wr_cnt - rd_cnt), 32'd3);
    chk("t2_occ_full", 32'(dut.w_occ), 32'd3);
    m_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("t2_no_gap", 32'(m_valid), 32'((k <= 5) ? 1 : 0));
      tick();
    end
    drain(50);
    chk("t2_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));

    // Alternating ready over ten words
    for (int i = 0; i < 10; i++) load(16'hA000 + 16'(i));
    for (int k = 0; k < 30; k++) begin
      m_ready = (k % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    drain(50);
    chk("t3_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));

    // Flush the cycle after a read, with two words buffered
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) load(16'hC000 + 16'(i));
    @(negedge clk);
    chk("t4_rd_c0", 32'(fifo_rd_en), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t4_rd_c2", 32'(fifo_rd_en), 32'd1);
    tick();
    flush = 1'b1;
    exp_q.delete();
    exp_cnt = exp_cnt - 16'd3;
    @(negedge clk);
    chk("t4_valid_before_flush", 32'(m_valid), 32'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_valid_after_flush", 32'(m_valid), 32'd0);
    chk("t4_busy_after_flush", 32'(busy), 32'd0);
    chk("t4_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    tick();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_dropped_stays_gone", 32'(m_valid), 32'd0);
      tick();
    end

    // One-cycle reset mid-stream with two words buffered
    m_ready = 1'b0;
    load(16'hD000);
    load(16'hD001);
    repeat (4) tick();
    @(negedge clk);
    chk("t5_valid_before_reset", 32'(m_valid), 32'd1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("t5_rst_m_data", 32'(m_data), 32'd0);
    chk("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) load(16'hE000 + 16'(i));
    drain(50);
    chk("t5_xfer_cnt", 32'(xfer_cnt), 32'd4);

    // Counter wrap: bring count to 0xFFFE, then three more handshakes
    for (int i = 0; i < 65530; i++) load(16'(i * 7 + 3));
    drain(70000);
    chk("t6_cnt_fffe", 32'(xfer_cnt), 32'h0000FFFE);
    load(16'h1111);
    load(16'h2222);
    load(16'h3333);
    drain(50);
    chk("t6_cnt_wrap", 32'(xfer_cnt), 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
